stopwatch_core: RTL and testbench

Parametrised mixed-radix stopwatch/timer core that generalises the fixed four-digit MM:SS counter chain into an N-digit counter with per-digit radix. It adds start/pause/clear control, runtime count direction, preset load and countdown-to-zero termination. It sits between the board clock and the digit display driver, and exposes packed BCD-style nibbles.

---
 rtl/stopwatch_pkg.sv | 29 ++
 rtl/mixed_radix_digit.sv | 52 +++++
 rtl/stopwatch_core.sv | 153 +++++++++++++++
 tb/tb_stopwatch_core.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the mixed-radix stopwatch core.
// Optional lap capture is enabled with STOPWATCH_LAP_EN.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } sw_state_t;

    localparam int NIB_W      = 4;
    localparam int MAX_DIGITS = 8;

    function automatic logic [NIB_W-1:0] clamp_digit(
        input logic [NIB_W-1:0] value,
        input logic [NIB_W-1:0] base
    );
        return (value >= base) ? base - 4'd1 : value;
    endfunction

    function automatic logic [NIB_W-1:0] base_of(
        input logic [NIB_W*MAX_DIGITS-1:0] bases,
        input int                          i
    );
        return bases[i*NIB_W +: NIB_W];
    endfunction

endpackage

// File: rtl/mixed_radix_digit.sv
// One digit register of the stopwatch chain with its own radix.
// Exposes the pre-edge next value when STOPWATCH_LAP_EN is defined.
module mixed_radix_digit
    import stopwatch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NIB_W-1:0] base,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [NIB_W-1:0] load_value,
    input  logic             clear,
    output logic [NIB_W-1:0] value,
`ifdef STOPWATCH_LAP_EN
    output logic [NIB_W-1:0] nxt,
`endif
    output logic             at_max,
    output logic             at_zero
);

    logic [NIB_W-1:0] value_d;

    assign at_max  = (value == base - 4'd1);
    assign at_zero = (value == '0);

    always_comb begin
        value_d = value;
        if (clear) begin
            value_d = '0;
        end else if (load) begin
            value_d = clamp_digit(load_value, base);
        end else if (inc) begin
            value_d = at_max ? '0 : value + 4'd1;
        end else if (dec) begin
            value_d = at_zero ? base - 4'd1 : value - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else begin
            value <= value_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    assign nxt = value_d;
`endif

endmodule

// File: rtl/stopwatch_core.sv
// N-digit mixed-radix stopwatch/timer with run control and countdown.
// Define STOPWATCH_LAP_EN to add the lap input and lap_digits snapshot.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int                  NUM_DIGITS  = 4,
    parameter logic [4*NUM_DIGITS-1:0] DIGIT_BASES =
        {4'd6, 4'd10, 4'd6, 4'd10},
    parameter int                  CLK_HZ      = 100_000_000,
    parameter int                  TICK_HZ     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_stop,
    input  logic                      clear,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_value,
    input  logic                      up_down,
`ifdef STOPWATCH_LAP_EN
    input  logic                      lap,
    output logic [4*NUM_DIGITS-1:0]   lap_digits,
`endif
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic                      running,
    output logic                      tick,
    output logic                      wrap,
    output logic                      done
);

    localparam int DIVISOR = CLK_HZ / TICK_HZ;
    localparam int PW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIVISOR - 1);

    if (DIVISOR < 2) begin : g_bad_divisor
        $error("stopwatch_core: CLK_HZ/TICK_HZ must be >= 2");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("stopwatch_core: NUM_DIGITS must be 1..8");
    end

    sw_state_t                 state, state_d;
    logic [PW-1:0]             presc, presc_d;
    logic                      wrap_d;
    logic [NUM_DIGITS-1:0]     at_max, at_zero, inc, dec;
    logic [NUM_DIGITS:0]       max_chain, zero_chain;
    logic                      all_max, all_zero, one_left;
    logic                      up_tick, dn_tick;
`ifdef STOPWATCH_LAP_EN
    logic [4*NUM_DIGITS-1:0]   digits_nxt;
`endif

    assign tick    = (state == RUN) && (presc == PMAX);
    assign up_tick = tick && up_down;
    assign dn_tick = tick && !up_down;
    assign running = (state == RUN);
    assign done    = (state == DONE);

    assign max_chain[0]  = 1'b1;
    assign zero_chain[0] = 1'b1;
    assign all_max       = max_chain[NUM_DIGITS];
    assign all_zero      = zero_chain[NUM_DIGITS];

    // Last down step: every upper digit zero and the LSB digit at one.
    assign one_left = (&(at_zero | NUM_DIGITS'(1)))
                   && (digits[NIB_W-1:0] == 4'd1);

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        assign max_chain[i+1]  = max_chain[i] & at_max[i];
        assign zero_chain[i+1] = zero_chain[i] & at_zero[i];
        assign inc[i] = up_tick && max_chain[i];
        assign dec[i] = dn_tick && !all_zero && zero_chain[i];

        mixed_radix_digit u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .base       (base_of(32'(DIGIT_BASES), i)),
            .inc        (inc[i]),
            .dec        (dec[i]),
            .load       (load),
            .load_value (load_value[i*NIB_W +: NIB_W]),
            .clear      (clear),
            .value      (digits[i*NIB_W +: NIB_W]),
`ifdef STOPWATCH_LAP_EN
            .nxt        (digits_nxt[i*NIB_W +: NIB_W]),
`endif
            .at_max     (at_max[i]),
            .at_zero    (at_zero[i])
        );
    end

    always_comb begin
        state_d = state;
        presc_d = presc;
        wrap_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            presc_d = '0;
        end else if (load) begin
            state_d = PAUSE;
            presc_d = '0;
        end else begin
            wrap_d = up_tick && all_max;
            if (state == RUN) begin
                presc_d = tick ? '0 : presc + PW'(1);
            end
            unique case (state)
                IDLE: begin
                    if (start_stop) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    if (start_stop) begin
                        state_d = PAUSE;
                    end else if (dn_tick && (all_zero || one_left)) begin
                        state_d = DONE;
                    end
                end
                PAUSE: begin
                    if (start_stop) begin
                        state_d = RUN;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            presc <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_d;
            presc <= presc_d;
            wrap  <= wrap_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            lap_digits <= '0;
        end else if (lap) begin
            lap_digits <= digits_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with DIVISOR = 10.
// Lap checks are compiled in when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic        up_down = 1'b1;
    logic [15:0] load_value = '0;
    logic [15:0] digits;
    logic        running, tick, wrap, done;
`ifdef STOPWATCH_LAP_EN
    logic        lap = 1'b0;
    logic [15:0] lap_digits;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        ss;
        logic        cl;
        logic        ld;
        logic [15:0] v;
        logic        ud;
        int          wt;
        logic [15:0] ed;
        logic        er;
        logic        edn;
    } vec_t;

    vec_t tbl[13];

    always #5 clk = ~clk;

    stopwatch_core #(
        .NUM_DIGITS  (4),
        .DIGIT_BASES ({4'd6, 4'd10, 4'd6, 4'd10}),
        .CLK_HZ      (10),
        .TICK_HZ     (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .up_down    (up_down),
`ifdef STOPWATCH_LAP_EN
        .lap        (lap),
        .lap_digits (lap_digits),
`endif
        .digits     (digits),
        .running    (running),
        .tick       (tick),
        .wrap       (wrap),
        .done       (done)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse(input logic ss, input logic cl, input logic ld,
                         input logic [15:0] v);
        start_stop = ss;
        clear      = cl;
        load       = ld;
        load_value = v;
        step();
        start_stop = 1'b0;
        clear      = 1'b0;
        load       = 1'b0;
    endtask

    // Cycle index (1 = cycle right after the last edge) of the next tick.
    task automatic wait_tick(output int n);
        n = 1;
        while (!tick && n < 50) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int wraps;

        //         ss cl ld value    ud wt   digits   run done
        tbl[0]  = '{1, 0, 0, 16'h0000, 1, 10, 16'h0001, 1, 0};
        tbl[1]  = '{0, 0, 0, 16'h0000, 1, 589, 16'h0100, 1, 0};
        tbl[2]  = '{0, 0, 1, 16'h5959, 1, 0, 16'h5959, 0, 0};
        tbl[3]  = '{1, 0, 0, 16'h0000, 1, 10, 16'h0000, 1, 0};
        tbl[4]  = '{0, 0, 1, 16'h0002, 0, 0, 16'h0002, 0, 0};
        tbl[5]  = '{1, 0, 0, 16'h0000, 0, 10, 16'h0001, 1, 0};
        tbl[6]  = '{0, 0, 0, 16'h0000, 0, 9, 16'h0000, 0, 1};
        tbl[7]  = '{1, 0, 0, 16'h0000, 0, 30, 16'h0000, 0, 1};
        tbl[8]  = '{1, 1, 1, 16'h1234, 0, 0, 16'h0000, 0, 0};
        tbl[9]  = '{0, 0, 1, 16'hFFFF, 0, 0, 16'h5959, 0, 0};
        tbl[10] = '{0, 0, 1, 16'h1A3B, 0, 0, 16'h1939, 0, 0};
        tbl[11] = '{0, 0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0};
        tbl[12] = '{1, 0, 0, 16'h0000, 0, 10, 16'h0000, 0, 1};

        rst_n = 1'b0;
        idle(2);
        chk("reset digits", 32'(digits), 32'h0);
        chk("reset running", 32'(running), 32'h0);
        chk("reset tick", 32'(tick), 32'h0);
        chk("reset wrap", 32'(wrap), 32'h0);
        chk("reset done", 32'(done), 32'h0);
`ifdef STOPWATCH_LAP_EN
        chk("reset lap_digits", 32'(lap_digits), 32'h0);
`endif
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 13; i++) begin
            up_down = tbl[i].ud;
            pulse(tbl[i].ss, tbl[i].cl, tbl[i].ld, tbl[i].v);
            idle(tbl[i].wt);
            chk($sformatf("vec%0d digits", i), 32'(digits),
                32'(tbl[i].ed));
            chk($sformatf("vec%0d running", i), 32'(running),
                32'(tbl[i].er));
            chk($sformatf("vec%0d done", i), 32'(done),
                32'(tbl[i].edn));
        end

        // First tick lands in cycle 10 after the start edge.
        pulse(0, 1, 0, 16'h0);
        up_down = 1'b1;
        pulse(1, 0, 0, 16'h0);
        wait_tick(n);
        chk("start latency", 32'(n), 32'd10);
        chk("digits at first tick", 32'(digits), 32'h0);
        step();
        chk("digits after first tick", 32'(digits), 32'h0001);

        // Up rollover from 59:59 pulses wrap exactly once.
        pulse(0, 0, 1, 16'h5959);
        pulse(1, 0, 0, 16'h0);
        wait_tick(n);
        chk("wrap tick latency", 32'(n), 32'd10);
        chk("wrap before edge", 32'(wrap), 32'h0);
        step();
        chk("wrap pulse", 32'(wrap), 32'h1);
        chk("wrap digits", 32'(digits), 32'h0);
        chk("wrap running", 32'(running), 32'h1);
        wraps = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (wrap) wraps++;
        end
        chk("wrap single", 32'(wraps), 32'd0);

        // Pause after 5 running cycles keeps the partial period.
        pulse(0, 1, 0, 16'h0);
        pulse(1, 0, 0, 16'h0);
        idle(4);
        pulse(1, 0, 0, 16'h0);
        chk("paused running", 32'(running), 32'h0);
        idle(100);
        chk("paused digits", 32'(digits), 32'h0);
        pulse(1, 0, 0, 16'h0);
        wait_tick(n);
        chk("resume latency", 32'(n), 32'd5);

`ifdef STOPWATCH_LAP_EN
        pulse(0, 1, 0, 16'h0);
        pulse(0, 0, 1, 16'h0009);
        pulse(1, 0, 0, 16'h0);
        wait_tick(n);
        chk("lap tick latency", 32'(n), 32'd10);
        chk("lap pre digits", 32'(digits), 32'h0009);
        lap = 1'b1;
        step();
        lap = 1'b0;
        chk("lap capture", 32'(lap_digits), 32'h0010);
        chk("lap digits", 32'(digits), 32'h0010);
        idle(10);
        chk("lap hold", 32'(lap_digits), 32'h0010);
        chk("lap continue", 32'(digits), 32'h0011);
`else
        idle(3);
`endif

        // Synchronous reset in the middle of a run.
        chk("pre-reset running", 32'(running), 32'h1);
        rst_n = 1'b0;
        step();
        chk("midrst digits", 32'(digits), 32'h0);
        chk("midrst running", 32'(running), 32'h0);
        chk("midrst tick", 32'(tick), 32'h0);
        chk("midrst wrap", 32'(wrap), 32'h0);
        chk("midrst done", 32'(done), 32'h0);
`ifdef STOPWATCH_LAP_EN
        chk("midrst lap_digits", 32'(lap_digits), 32'h0);
`endif
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
